// File: rtl/id_digit_sequencer.sv
// id_digit_sequencer
//   Steps through a compile-time table of NUM_DIGITS digits and presents the
//   current digit on student_id. data_in is the advance strobe. The direction
//   is latched when a run starts. At the end of the table the sequencer either
//   wraps, which pulses wrap_pulse and bumps a saturating lap counter, or stops
//   in DONE until clear is asserted.
//
// Ports
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset; has the highest priority
//   data_in       in   advance strobe
//   dir           in   0 = ascending, 1 = descending (latched on IDLE->RUN)
//   wrap          in   1 = wrap at end of table, 0 = stop in DONE (live)
//   clear         in   synchronous return to IDLE; keeps lap_count
//   student_id    out  current digit (0 outside RUN)
//   current_state out  current digit index
//   valid         out  high while in RUN
//   done          out  high while in DONE
//   wrap_pulse    out  one-cycle pulse on each wrap
//   lap_count     out  wraps since reset, saturating
module id_digit_sequencer #(
   parameter int DIGIT_W    = 4,
   parameter int NUM_DIGITS = 8,
   parameter int STATE_W    = 4,
   parameter logic [NUM_DIGITS*DIGIT_W-1:0] ID_DIGITS = 32'h5012_3456,
   parameter int LAP_W      = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               data_in,
   input  logic               dir,
   input  logic               wrap,
   input  logic               clear,
   output logic [DIGIT_W-1:0] student_id,
   output logic [STATE_W-1:0] current_state,
   output logic               valid,
   output logic               done,
   output logic               wrap_pulse,
   output logic [LAP_W-1:0]   lap_count
);

   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_RUN  = 2'd1,
      PH_DONE = 2'd2
   } phase_t;

   localparam logic [STATE_W-1:0] LAST_IDX = STATE_W'(NUM_DIGITS - 1);
   localparam logic [STATE_W-1:0] ZERO_IDX = '0;

   // Table lookup, digit 0 sits in the most significant slot of ID_DIGITS.
   function automatic logic [DIGIT_W-1:0] digit_at(input logic [STATE_W-1:0] idx);
      logic [DIGIT_W-1:0] d;
      d = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx == STATE_W'(i)) begin
            d = ID_DIGITS[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W];
         end
      end
      return d;
   endfunction

   function automatic logic [STATE_W-1:0] start_idx(input logic desc);
      return desc ? LAST_IDX : ZERO_IDX;
   endfunction

   function automatic logic [STATE_W-1:0] end_idx(input logic desc);
      return desc ? ZERO_IDX : LAST_IDX;
   endfunction

   // Lap counter holds at all-ones instead of rolling over.
   function automatic logic [LAP_W-1:0] lap_sat_inc(input logic [LAP_W-1:0] v);
      return (&v) ? v : v + LAP_W'(1);
   endfunction

   phase_t             phase_q, phase_d;
   logic               dir_q, dir_d;
   logic [STATE_W-1:0] idx_q, idx_d;
   logic [DIGIT_W-1:0] sid_q, sid_d;
   logic               valid_q, valid_d;
   logic               done_q, done_d;
   logic               wp_q, wp_d;
   logic [LAP_W-1:0]   lap_q, lap_d;

   always_comb begin
      phase_d = phase_q;
      dir_d   = dir_q;
      idx_d   = idx_q;
      sid_d   = sid_q;
      valid_d = valid_q;
      done_d  = done_q;
      wp_d    = 1'b0;
      lap_d   = lap_q;

      if (clear) begin
         // clear outranks data_in in every phase: no start, no advance.
         phase_d = PH_IDLE;
         idx_d   = '0;
         sid_d   = '0;
         valid_d = 1'b0;
         done_d  = 1'b0;
      end else begin
         unique case (phase_q)
            PH_IDLE: begin
               if (data_in) begin
                  phase_d = PH_RUN;
                  dir_d   = dir;
                  idx_d   = start_idx(dir);
                  sid_d   = digit_at(start_idx(dir));
                  valid_d = 1'b1;
                  done_d  = 1'b0;
               end
            end
            PH_RUN: begin
               if (data_in) begin
                  if (idx_q == end_idx(dir_q)) begin
                     if (wrap) begin
                        idx_d = start_idx(dir_q);
                        sid_d = digit_at(start_idx(dir_q));
                        wp_d  = 1'b1;
                        lap_d = lap_sat_inc(lap_q);
                     end else begin
                        // Index stays parked on the end entry while DONE.
                        phase_d = PH_DONE;
                        sid_d   = '0;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                     end
                  end else begin
                     idx_d = dir_q ? idx_q - STATE_W'(1) : idx_q + STATE_W'(1);
                     sid_d = digit_at(idx_d);
                  end
               end
            end
            PH_DONE: begin
               // Only clear or reset leaves DONE.
            end
            default: begin
               phase_d = PH_IDLE;
               idx_d   = '0;
               sid_d   = '0;
               valid_d = 1'b0;
               done_d  = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase_q <= PH_IDLE;
         dir_q   <= 1'b0;
         idx_q   <= '0;
         sid_q   <= '0;
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         wp_q    <= 1'b0;
         lap_q   <= '0;
      end else begin
         phase_q <= phase_d;
         dir_q   <= dir_d;
         idx_q   <= idx_d;
         sid_q   <= sid_d;
         valid_q <= valid_d;
         done_q  <= done_d;
         wp_q    <= wp_d;
         lap_q   <= lap_d;
      end
   end

   assign student_id    = sid_q;
   assign current_state = idx_q;
   assign valid         = valid_q;
   assign done          = done_q;
   assign wrap_pulse    = wp_q;
   assign lap_count     = lap_q;

endmodule

// File: doc/id_digit_sequencer.md
Name: id_digit_sequencer

Overview:
Parametrised successor to the fixed 4-bit student-ID state machine. It steps through a compile-time table of NUM_DIGITS digits, each DIGIT_W bits wide, and presents one digit per step on student_id. data_in is the advance strobe. Added over the original: selectable direction, wrap versus one-shot mode, a synchronous clear, a lap counter and status flags. It sits beside the simple processor as a display/ID source driven by the same clk/reset.

Parameters:
DIGIT_W, 4, width of each digit and of student_id.
NUM_DIGITS, 8, number of digits in the table; legal range 2..2**STATE_W.
STATE_W, 4, width of current_state (digit index).
ID_DIGITS, 32'h5012_3456, packed table of NUM_DIGITS*DIGIT_W bits. Digit i = ID_DIGITS[(NUM_DIGITS-1-i)*DIGIT_W +: DIGIT_W], so the hex literal reads left-to-right as digit 0, 1, …
LAP_W, 4, width of lap_count.

Ports:
clk  input  1  system clock; all logic on the rising edge.
reset  input  1  synchronous, active-high; dominates every other input.
data_in  input  1  advance strobe; sampled every rising edge.
dir  input  1  0 = ascending index, 1 = descending; latched only on the IDLE->RUN transition.
wrap  input  1  1 = wrap at end of table, 0 = stop in DONE; sampled live every cycle.
clear  input  1  synchronous return to IDLE without resetting lap_count.
student_id  output  DIGIT_W  current digit, registered.
current_state  output  STATE_W  current digit index, registered.
valid  output  1  high while in RUN.
done  output  1  high while in DONE.
wrap_pulse  output  1  one-cycle pulse on each wrap.
lap_count  output  LAP_W  number of wraps since reset; saturates at all-ones.

Behaviour:
- All outputs are registered. A change caused by the inputs at edge N is visible after edge N.
- Reset (reset=1 at an edge):
  - phase=IDLE, current_state=0, student_id=0, valid=0, done=0, wrap_pulse=0, lap_count=0, latched dir=0.
  - Reset behaves the same mid-run and in DONE.
- Phase FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - Outputs: student_id=0, valid=0, done=0.
  - data_in=1 -> RUN. dir is latched; start index S = 0 if dir=0, NUM_DIGITS-1 if dir=1. current_state=S, student_id=digit[S], valid=1.
  - data_in=0 -> stay in IDLE.
- RUN:
  - data_in=0: hold index and digit.
  - data_in=1, not at the end index E (E = NUM_DIGITS-1 ascending, 0 descending): index moves +1 or -1 per the latched dir, and student_id follows.
  - data_in=1 at E, wrap=1: index = S, student_id = digit[S], wrap_pulse=1 for exactly one cycle, lap_count += 1 unless it is already all-ones.
  - data_in=1 at E, wrap=0: -> DONE.
  - Index never leaves 0..NUM_DIGITS-1. Index arithmetic is modulo-free: compare against E explicitly.
- DONE:
  - Outputs: valid=0, done=1, student_id=0; current_state keeps E.
  - data_in is ignored.
  - clear=1 -> IDLE, with current_state=0 and done=0.
- clear:
  - In RUN or DONE, clear=1 -> IDLE on the next edge. It takes priority over data_in on the same edge (no advance and no start).
  - In IDLE, clear=1 wins over data_in: stay in IDLE.
  - lap_count is preserved.
- Priority order: reset > clear > data_in.
- dir changes during RUN have no effect until the next IDLE->RUN transition.
- wrap_pulse is 0 in every cycle other than the wrap cycle.

Test Plan:
1. Reset, then data_in=1 for 8 consecutive cycles with dir=0, wrap=0 -> student_id shows 5,0,1,2,3,4,5,6 and current_state 0..7 on successive cycles; the next data_in=1 gives done=1, valid=0, student_id=0.
2. dir=1, wrap=1, data_in held high for 17 cycles -> digits 6,5,4,3,2,1,0,5, then 6… (wrap back to index 7); wrap_pulse high exactly on the two wrap cycles; lap_count=2.
3. In RUN at index 3, toggle data_in 1,0,0,1 -> index 4,4,4,5 (hold on 0). Flip dir mid-run -> direction unchanged.
4. In DONE, drive data_in=1 for 3 cycles -> stays DONE. Assert clear with data_in=1 -> IDLE, current_state=0, done=0; the following data_in=1 restarts at index 0.
5. Reset mid-run at index 5 with lap_count=3 -> next cycle all outputs 0, including lap_count; clear at the same point instead -> IDLE with lap_count=3.
6. Wrap 20 times with LAP_W=4 -> lap_count saturates at 15, and wrap_pulse still pulses on each wrap.
